// File: rtl/bpred_pkg.sv
// Shared types and counter helpers for the IF-stage branch predictor.
// Struct fields are sized for the widest supported configuration; narrower builds zero-extend.
package bpred_pkg;

  localparam int BP_XLEN_MAX = 32;
  localparam int CNT_W_MAX   = 8;

  typedef enum logic [1:0] {
    BR   = 2'd0,
    JAL  = 2'd1,
    CALL = 2'd2,
    RET  = 2'd3
  } br_type_e;

  typedef logic [CNT_W_MAX-1:0] cnt_t;

  typedef struct packed {
    logic                   valid;
    logic [BP_XLEN_MAX-1:0] tag;
    br_type_e               btype;
    logic [BP_XLEN_MAX-1:0] target;
    cnt_t                   cnt;
  } btb_entry_t;

  // Weakly-not-taken: the reset value of every counter.
  function automatic cnt_t cnt_init(input int w);
    return cnt_t'((1 << (w - 1)) - 1);
  endfunction

  // Weakly-taken: the value given to a freshly allocated entry.
  function automatic cnt_t cnt_weak_taken(input int w);
    return cnt_t'(1 << (w - 1));
  endfunction

  function automatic cnt_t cnt_max(input int w);
    return cnt_t'((1 << w) - 1);
  endfunction

  function automatic logic cnt_is_taken(input cnt_t cnt, input int w);
    return cnt >= cnt_weak_taken(w);
  endfunction

endpackage

// File: rtl/bpred_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Only instantiated by bpred_btb when BPRED_RAS_EN is defined.
module bpred_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_addr_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [XLEN-1:0]  stack_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W:0]   cnt_q;

  assign empty_o = (cnt_q == '0);
  assign top_o   = stack_q[ptr_q - PTR_W'(1)];

  // ptr_q always names the next slot to write, which is also the oldest slot once full.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else if (push_i) begin
      stack_q[ptr_q] <= push_addr_i;
      ptr_q          <= ptr_q + PTR_W'(1);
      if (cnt_q != FULL_CNT) cnt_q <= cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_q <= ptr_q - PTR_W'(1);
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/bpred_btb.sv
// Direct-mapped BTB with saturating direction counters: combinational lookup, training on the clock edge.
// Define BPRED_RAS_EN to add a return-address stack that supplies targets for RET entries.
module bpred_btb
  import bpred_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int CNT_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  br_type_e        upd_type_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  output logic            hit_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef logic [BP_XLEN_MAX-1:0] word_t;

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 || CNT_W < 1 || CNT_W > CNT_W_MAX ||
      XLEN > BP_XLEN_MAX || XLEN < IDX_W + 3 ||
      RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_params
    $error("bpred_btb: unsupported parameter combination");
  end

  btb_entry_t       btb_q [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  word_t            f_tag;
  btb_entry_t       f_ent;
  logic             f_hit;
  word_t            f_target;

  logic [IDX_W-1:0] u_idx;
  word_t            u_tag;
  logic             u_hit;
  cnt_t             u_cnt;
  cnt_t             u_cnt_next;

  assign f_idx = fetch_pc_i[IDX_W+1:2];
  assign f_tag = word_t'(fetch_pc_i >> (IDX_W + 2));
  assign f_ent = btb_q[f_idx];
  assign f_hit = f_ent.valid && (f_ent.tag == f_tag);

`ifdef BPRED_RAS_EN
  logic            ras_empty;
  logic [XLEN-1:0] ras_top;

  bpred_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (upd_valid_i && (upd_type_i == CALL)),
    .pop_i       (upd_valid_i && (upd_type_i == RET)),
    .push_addr_i (upd_pc_i + XLEN'(4)),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );

  assign f_target = (f_ent.btype == RET && !ras_empty) ? word_t'(ras_top) : f_ent.target;
`else
  assign f_target = f_ent.target;
`endif

  // Jumps always redirect on a hit; conditional branches follow the counter's upper half.
  always_comb begin
    hit_o         = f_hit;
    pred_taken_o  = 1'b0;
    pred_target_o = '0;
    if (f_hit) begin
      pred_taken_o  = (f_ent.btype != BR) || cnt_is_taken(f_ent.cnt, CNT_W);
      pred_target_o = f_target[XLEN-1:0] & ~XLEN'(1);
    end
  end

  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = word_t'(upd_pc_i >> (IDX_W + 2));
  assign u_hit = btb_q[u_idx].valid && (btb_q[u_idx].tag == u_tag);
  assign u_cnt = btb_q[u_idx].cnt;

  always_comb begin
    u_cnt_next = u_cnt;
    if (upd_taken_i) begin
      if (u_cnt != cnt_max(CNT_W)) u_cnt_next = u_cnt + cnt_t'(1);
    end else if (u_cnt != '0) begin
      u_cnt_next = u_cnt - cnt_t'(1);
    end
  end

  // Every write is gated by upd_valid_i so idle-cycle garbage on upd_* never reaches the table.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, btype: BR, target: '0, cnt: cnt_init(CNT_W)};
      end
    end else if (upd_valid_i) begin
      if (u_hit) begin
        btb_q[u_idx].cnt   <= u_cnt_next;
        btb_q[u_idx].btype <= upd_type_i;
        if (upd_taken_i) btb_q[u_idx].target <= word_t'(upd_target_i);
      end else if (upd_taken_i) begin
        btb_q[u_idx] <= '{valid: 1'b1, tag: u_tag, btype: upd_type_i,
                          target: word_t'(upd_target_i), cnt: cnt_weak_taken(CNT_W)};
      end
    end
  end

endmodule

// File: tb/tb_bpred_btb.sv
// Self-checking bench for bpred_btb: directed scenarios plus randomized traffic against a queue/array model.
// Exercises the return-address stack when BPRED_RAS_EN is defined.
module tb_bpred_btb;
  import bpred_pkg::*;

  localparam int XLEN      = 32;
  localparam int ENTRIES   = 16;
  localparam int CNT_W     = 2;
  localparam int RAS_DEPTH = 4;
  localparam int IDX_W     = $clog2(ENTRIES);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  br_type_e    upd_type = BR;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        hit;
  logic [33:0] got;

  int n_vec = 0;
  int n_err = 0;

  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  br_type_e    m_type   [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_cnt    [ENTRIES];
  logic [31:0] m_ras    [$];

  bpred_btb #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .fetch_pc_i    (fetch_pc),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .upd_valid_i   (upd_valid),
    .upd_pc_i      (upd_pc),
    .upd_type_i    (upd_type),
    .upd_taken_i   (upd_taken),
    .upd_target_i  (upd_target),
    .hit_o         (hit)
  );

  assign got = {hit, pred_taken, pred_target};

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 2 ** (CNT_W - 1) - 1;
    end
    m_ras.delete();
  endfunction

  function automatic void model_update(input logic [31:0] pc, input br_type_e t,
                                       input logic tk, input logic [31:0] tg);
    int unsigned idx;
    logic [31:0] tag;
    idx = int'((pc >> 2) % ENTRIES);
    tag = pc >> (2 + IDX_W);
    if (m_valid[idx] && m_tag[idx] == tag) begin
      if (tk) begin
        m_cnt[idx]    = (m_cnt[idx] + 1 > 2 ** CNT_W - 1) ? 2 ** CNT_W - 1 : m_cnt[idx] + 1;
        m_target[idx] = tg;
      end else begin
        m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
      end
      m_type[idx] = t;
    end else if (tk) begin
      m_valid[idx]  = 1'b1;
      m_tag[idx]    = tag;
      m_type[idx]   = t;
      m_target[idx] = tg;
      m_cnt[idx]    = 2 ** (CNT_W - 1);
    end
`ifdef BPRED_RAS_EN
    if (t == CALL) begin
      m_ras.push_back(pc + 32'd4);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end else if (t == RET && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
`endif
  endfunction

  function automatic logic [33:0] model_predict(input logic [31:0] pc);
    int unsigned idx;
    logic [31:0] tg;
    logic        tk;
    idx = int'((pc >> 2) % ENTRIES);
    if (!(m_valid[idx] && m_tag[idx] == (pc >> (2 + IDX_W)))) return '0;
    tk = (m_type[idx] != BR) || (m_cnt[idx] >= 2 ** (CNT_W - 1));
    tg = m_target[idx];
`ifdef BPRED_RAS_EN
    if (m_type[idx] == RET && m_ras.size() > 0) tg = m_ras[$];
`endif
    return {1'b1, tk, tg & 32'hFFFF_FFFE};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input br_type_e t,
                       input logic tk, input logic [31:0] tg, input logic [31:0] fpc);
    @(negedge clk);
    upd_valid  = v;
    upd_pc     = pc;
    upd_type   = t;
    upd_taken  = tk;
    upd_target = tg;
    fetch_pc   = fpc;
    #1;
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    if (upd_valid) model_update(upd_pc, upd_type, upd_taken, upd_target);
    upd_valid = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input br_type_e t, input logic tk, input logic [31:0] tg);
    drive(1'b1, pc, t, tk, tg, fetch_pc);
    commit();
  endtask

  task automatic lookup(input logic [31:0] fpc);
    drive(1'b0, $urandom, br_type_e'($urandom_range(0, 3)), 1'($urandom), $urandom, fpc);
  endtask

  task automatic test_reset();
    fetch_pc = 32'h100;
    model_reset();
    #1 rst_n = 1'b0;
    #12;
    n_vec++; if (got !== 34'd0) begin n_err++; $display("FAIL reset_held: got %h want %h", got, 34'd0); end
    @(negedge clk) rst_n = 1'b1;
    lookup(32'h100);
    n_vec++; if (got !== 34'd0) begin n_err++; $display("FAIL reset_lookup: got %h want %h", got, 34'd0); end
  endtask

  task automatic test_basic();
    train(32'h100, BR, 1'b1, 32'h80);
    lookup(32'h100);
    n_vec++; if (got !== {1'b1, 1'b1, 32'h80}) begin n_err++; $display("FAIL basic_alloc: got %h want %h", got, {1'b1, 1'b1, 32'h80}); end
  endtask

  task automatic test_counter();
    bit tk_seq [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int rep    [6] = '{1, 2, 1, 1, 3, 1};
    bit exp_tk [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      repeat (rep[i]) train(32'h100, BR, tk_seq[i], tk_seq[i] ? 32'h80 : 32'h5550);
      lookup(32'h100);
      n_vec++;
      if (got !== {1'b1, exp_tk[i], 32'h80}) begin
        n_err++; $display("FAIL counter_step%0d: got %h want %h", i, got, {1'b1, exp_tk[i], 32'h80});
      end
    end
  endtask

  task automatic test_alias();
    train(32'h100 + 4 * ENTRIES, JAL, 1'b1, 32'h400);
    lookup(32'h100);
    n_vec++; if (got !== 34'd0) begin n_err++; $display("FAIL alias_evicted: got %h want %h", got, 34'd0); end
    lookup(32'h100 + 4 * ENTRIES);
    n_vec++; if (got !== {1'b1, 1'b1, 32'h400}) begin n_err++; $display("FAIL alias_new: got %h want %h", got, {1'b1, 1'b1, 32'h400}); end
  endtask

  task automatic test_no_alloc();
    train(32'h200, BR, 1'b0, 32'h600);
    lookup(32'h200);
    n_vec++; if (got !== 34'd0) begin n_err++; $display("FAIL noalloc_200: got %h want %h", got, 34'd0); end
    lookup(32'h140);
    n_vec++; if (got !== {1'b1, 1'b1, 32'h400}) begin n_err++; $display("FAIL noalloc_kept: got %h want %h", got, {1'b1, 1'b1, 32'h400}); end
    train(32'h208, BR, 1'b0, 32'h700);
    lookup(32'h208);
    n_vec++; if (got !== 34'd0) begin n_err++; $display("FAIL noalloc_208: got %h want %h", got, 34'd0); end
  endtask

  task automatic test_target_bit0();
    train(32'h104, BR, 1'b1, 32'h301);
    lookup(32'h104);
    n_vec++; if (got !== {1'b1, 1'b1, 32'h300}) begin n_err++; $display("FAIL bit0_clear: got %h want %h", got, {1'b1, 1'b1, 32'h300}); end
    lookup(32'h107);
    n_vec++; if (got !== {1'b1, 1'b1, 32'h300}) begin n_err++; $display("FAIL pc_low_ignored: got %h want %h", got, {1'b1, 1'b1, 32'h300}); end
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 4; i++) begin
      lookup(32'h140);
      n_vec++; if (got !== {1'b1, 1'b1, 32'h400}) begin n_err++; $display("FAIL idle_hold%0d: got %h want %h", i, got, {1'b1, 1'b1, 32'h400}); end
    end
  endtask

`ifdef BPRED_RAS_EN
  task automatic test_ras();
    logic [31:0] exp_top [6] = '{32'h1018, 32'h1014, 32'h1010, 32'h100C, 32'h998, 32'h998};
    train(32'h300, RET, 1'b1, 32'h999);
    train(32'h48, CALL, 1'b1, 32'h800);
    lookup(32'h300);
    n_vec++; if (got !== {1'b1, 1'b1, 32'h4C}) begin n_err++; $display("FAIL ras_call_ret: got %h want %h", got, {1'b1, 1'b1, 32'h4C}); end
    for (int i = 0; i <= RAS_DEPTH; i++) train(32'h1004 + 32'(4 * i), CALL, 1'b1, 32'h2000);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) train(32'h300, RET, 1'b1, 32'h999);
      lookup(32'h300);
      n_vec++;
      if (got !== {1'b1, 1'b1, exp_top[i]}) begin
        n_err++; $display("FAIL ras_pop%0d: got %h want %h", i, got, {1'b1, 1'b1, exp_top[i]});
      end
    end
  endtask
`else
  task automatic test_ret_stored();
    train(32'h300, RET, 1'b1, 32'h999);
    train(32'h48, CALL, 1'b1, 32'h800);
    lookup(32'h300);
    n_vec++; if (got !== {1'b1, 1'b1, 32'h998}) begin n_err++; $display("FAIL ret_stored: got %h want %h", got, {1'b1, 1'b1, 32'h998}); end
    lookup(32'h48);
    n_vec++; if (got !== {1'b1, 1'b1, 32'h800}) begin n_err++; $display("FAIL call_as_jal: got %h want %h", got, {1'b1, 1'b1, 32'h800}); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] last_pc = 32'h100;
    logic [31:0] pc;
    logic [31:0] fpc;
    logic [33:0] exp;
    br_type_e    t;
    logic        v;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      pc  = $urandom_range(0, 1) ? last_pc : 32'($urandom_range(0, 1023));
      t   = br_type_e'($urandom_range(0, 3));
      fpc = $urandom_range(0, 1) ? last_pc : 32'($urandom_range(0, 1023));
      drive(v, pc, t, (t == BR) ? 1'($urandom) : 1'b1, $urandom, fpc);
      exp = model_predict(fpc);
      n_vec++; if (got !== exp) begin n_err++; $display("FAIL random%0d pc=%h: got %h want %h", i, fpc, got, exp); end
      commit();
      if (v) last_pc = pc;
    end
  endtask

  task automatic test_reset_mid_update();
    train(32'h140, JAL, 1'b1, 32'h400);
    drive(1'b1, 32'h208, BR, 1'b1, 32'h700, 32'h140);
    n_vec++; if (got !== {1'b1, 1'b1, 32'h400}) begin n_err++; $display("FAIL pre_reset: got %h want %h", got, {1'b1, 1'b1, 32'h400}); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (got !== 34'd0) begin n_err++; $display("FAIL async_reset_out: got %h want %h", got, 34'd0); end
    @(posedge clk);
    #1;
    model_reset();
    upd_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    lookup(32'h140);
    n_vec++; if (got !== 34'd0) begin n_err++; $display("FAIL reset_cleared: got %h want %h", got, 34'd0); end
    lookup(32'h208);
    n_vec++; if (got !== 34'd0) begin n_err++; $display("FAIL reset_blocks_upd: got %h want %h", got, 34'd0); end
    train(32'h100, BR, 1'b1, 32'h80);
    lookup(32'h100);
    n_vec++; if (got !== {1'b1, 1'b1, 32'h80}) begin n_err++; $display("FAIL post_reset_alloc: got %h want %h", got, {1'b1, 1'b1, 32'h80}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_counter();
    test_alias();
    test_no_alloc();
    test_target_bit0();
    test_idle_hold();
`ifdef BPRED_RAS_EN
    test_ras();
`else
    test_ret_stored();
`endif
    test_random();
    test_reset_mid_update();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d", n_vec);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
